// File: rtl/controlmux_pkg.sv
// Shared ID/EX control-mux select type: pass decoded control or force a NOP (all-zero).
package controlmux;

  typedef enum logic {
    ctrl = 1'b0,
    zero = 1'b1
  } controlmux_sel_t;

endpackage : controlmux

// File: rtl/stall_ctrl_pkg.sv
// Types, constants and helpers shared by the pipeline stall controller.
package stall_ctrl_pkg;

  // Watchdog/statistics FSM: which memory side (if any) the pipeline waits on.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    DMEM_WAIT = 2'd2
  } stall_state_t;

  // NOP loaded into IF/ID or ID/EX when a flush is asserted (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Number of statistics counters and their slot indices.
  localparam int unsigned N_STATS   = 3;
  localparam int unsigned STAT_STALL  = 0;
  localparam int unsigned STAT_BUBBLE = 1;
  localparam int unsigned STAT_FLUSH  = 2;

  // Per-stage enables and flushes produced by one control decision.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  // Everything held: memory freeze and reset.
  function automatic stage_ctrl_t ctrl_hold();
    return '{default: 1'b0};
  endfunction

  // Normal advance of every stage.
  function automatic stage_ctrl_t ctrl_advance();
    stage_ctrl_t c;
    c = '{default: 1'b0};
    c.pc_we     = 1'b1;
    c.if_id_we  = 1'b1;
    c.id_ex_we  = 1'b1;
    c.ex_mem_we = 1'b1;
    c.mem_wb_we = 1'b1;
    return c;
  endfunction

  // Redirect: advance everything and squash the two wrong-path stages.
  function automatic stage_ctrl_t ctrl_redirect();
    stage_ctrl_t c;
    c = ctrl_advance();
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  // Load-use bubble: hold PC and IF/ID, let the back end drain one slot.
  function automatic stage_ctrl_t ctrl_bubble();
    stage_ctrl_t c;
    c = ctrl_advance();
    c.pc_we    = 1'b0;
    c.if_id_we = 1'b0;
    return c;
  endfunction

endpackage : stall_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc_i cycles, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline control: one freeze / flush / bubble / advance decision per cycle,
// plus saturating stall statistics and a sticky memory-wait watchdog.
module pipeline_stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       HD_stall_i,
  input  logic                       EX_br_taken_i,
  input  logic                       IF_imem_read_i,
  input  logic                       IF_imem_resp_i,
  input  logic                       MEM_dmem_req_i,
  input  logic                       MEM_dmem_resp_i,
  output logic                       PC_write_o,
  output logic                       IF_ID_write_o,
  output logic                       ID_EX_write_o,
  output logic                       EX_MEM_write_o,
  output logic                       MEM_WB_write_o,
  output logic                       IF_ID_flush_o,
  output logic                       ID_EX_flush_o,
  output controlmux::controlmux_sel_t controlmux_sel_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           bubble_cnt_o,
  output logic [CNT_W-1:0]           flush_cnt_o,
  output logic                       err_o
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  // Memory wait qualifiers; a response in the request cycle is not a wait.
  logic imem_wait;
  logic dmem_wait;
  logic freeze;

  assign imem_wait = IF_imem_read_i & ~IF_imem_resp_i;
  assign dmem_wait = MEM_dmem_req_i & ~MEM_dmem_resp_i;
  assign freeze    = imem_wait | dmem_wait;

  stall_state_t state_q;
  stall_state_t state_d;

  logic [WD_W-1:0] wait_cnt_q;
  logic [WD_W-1:0] wait_cnt_d;
  logic            err_q;
  logic            err_d;

  stage_ctrl_t                 stage_ctrl;
  controlmux::controlmux_sel_t sel;
  logic [N_STATS-1:0]          stat_inc;
  logic [CNT_W-1:0]            stat_cnt [N_STATS];

  // State, watchdog count and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state: dmem waits take precedence over imem waits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (dmem_wait) begin
          state_d = DMEM_WAIT;
        end else if (imem_wait) begin
          state_d = IMEM_WAIT;
        end
      end
      IMEM_WAIT: begin
        if (dmem_wait) begin
          state_d = DMEM_WAIT;
        end else if (!freeze) begin
          state_d = RUN;
        end
      end
      DMEM_WAIT: begin
        if (!dmem_wait && imem_wait) begin
          state_d = IMEM_WAIT;
        end else if (!freeze) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Watchdog: counts edges spent entering/holding a wait state across IMEM<->DMEM
  // moves, clears when the FSM returns to RUN, flags once TIMEOUT waits have elapsed.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (state_d == RUN) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WD_LAST) begin
      wait_cnt_d = wait_cnt_q + WD_W'(1);
    end
    if (freeze && (wait_cnt_q == WD_LAST)) begin
      err_d = 1'b1;
    end
  end

  // Control decision: freeze > redirect > load-use bubble > advance; reset holds all.
  always_comb begin
    stage_ctrl = ctrl_advance();
    sel        = controlmux::ctrl;
    stat_inc   = '0;
    if (!rst) begin
      stage_ctrl = ctrl_hold();
      sel        = controlmux::zero;
    end else if (freeze) begin
      stage_ctrl            = ctrl_hold();
      stat_inc[STAT_STALL]  = 1'b1;
    end else if (EX_br_taken_i) begin
      stage_ctrl            = ctrl_redirect();
      sel                   = controlmux::zero;
      stat_inc[STAT_FLUSH]  = 1'b1;
    end else if (HD_stall_i) begin
      stage_ctrl            = ctrl_bubble();
      sel                   = controlmux::zero;
      stat_inc[STAT_BUBBLE] = 1'b1;
    end
  end

  // Statistics counters, one per decision class.
  for (genvar gi = 0; gi < N_STATS; gi++) begin : g_stats
    sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stat_inc[gi]),
      .cnt_o (stat_cnt[gi])
    );
  end

  assign PC_write_o       = stage_ctrl.pc_we;
  assign IF_ID_write_o    = stage_ctrl.if_id_we;
  assign ID_EX_write_o    = stage_ctrl.id_ex_we;
  assign EX_MEM_write_o   = stage_ctrl.ex_mem_we;
  assign MEM_WB_write_o   = stage_ctrl.mem_wb_we;
  assign IF_ID_flush_o    = stage_ctrl.if_id_flush;
  assign ID_EX_flush_o    = stage_ctrl.id_ex_flush;
  assign controlmux_sel_o = sel;
  assign stall_cnt_o      = stat_cnt[STAT_STALL];
  assign bubble_cnt_o     = stat_cnt[STAT_BUBBLE];
  assign flush_cnt_o      = stat_cnt[STAT_FLUSH];
  assign err_o            = err_q;

endmodule : pipeline_stall_ctrl

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed per-cycle vectors, decoupled monitor.
module tb_pipeline_stall_ctrl;
  import stall_ctrl_pkg::*;
  import controlmux::*;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hd = 1'b0, br = 1'b0, ird = 1'b0, irsp = 1'b0, dreq = 1'b0, drsp = 1'b0;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_fl, idex_fl, err;
  controlmux_sel_t sel;
  logic [CNT_W-1:0] s_cnt, b_cnt, f_cnt;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .HD_stall_i       (hd),
    .EX_br_taken_i    (br),
    .IF_imem_read_i   (ird),
    .IF_imem_resp_i   (irsp),
    .MEM_dmem_req_i   (dreq),
    .MEM_dmem_resp_i  (drsp),
    .PC_write_o       (pc_we),
    .IF_ID_write_o    (ifid_we),
    .ID_EX_write_o    (idex_we),
    .EX_MEM_write_o   (exmem_we),
    .MEM_WB_write_o   (memwb_we),
    .IF_ID_flush_o    (ifid_fl),
    .ID_EX_flush_o    (idex_fl),
    .controlmux_sel_o (sel),
    .stall_cnt_o      (s_cnt),
    .bubble_cnt_o     (b_cnt),
    .flush_cnt_o      (f_cnt),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [4:0]      en;
    logic [1:0]      fl;
    controlmux_sel_t sel;
    stall_state_t    st;
    int unsigned     s;
    int unsigned     b;
    int unsigned     f;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  localparam logic [4:0] A  = 5'b11111;
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] BU = 5'b00111;

  // Drive one cycle of inputs just after the rising edge and queue its expected response.
  task automatic vec(input string tag, input logic r, input logic i_hd, input logic i_br,
                     input logic i_ird, input logic i_irsp, input logic i_dreq, input logic i_drsp,
                     input logic [4:0] en, input logic [1:0] fl, input controlmux_sel_t xs,
                     input stall_state_t st, input int unsigned s, input int unsigned b,
                     input int unsigned f, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; hd = i_hd; br = i_br; ird = i_ird; irsp = i_irsp; dreq = i_dreq; drsp = i_drsp;
    x.tag = tag; x.en = en; x.fl = fl; x.sel = xs; x.st = st;
    x.s = s; x.b = b; x.f = f; x.err = e;
    exp_q.push_back(x);
  endtask

  function automatic void chk(string tag, string name, int unsigned act, int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, name, act, req);
    end
  endfunction

  // Monitor: every queued cycle is compared mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      int   e0;
      x  = exp_q.pop_front();
      e0 = errors;
      chk(x.tag, "enables", 32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we}), 32'(x.en));
      chk(x.tag, "flushes", 32'({ifid_fl, idex_fl}), 32'(x.fl));
      chk(x.tag, "sel", 32'(sel), 32'(x.sel));
      chk(x.tag, "state", 32'(dut.state_q), 32'(x.st));
      chk(x.tag, "stall_cnt", 32'(s_cnt), x.s);
      chk(x.tag, "bubble_cnt", 32'(b_cnt), x.b);
      chk(x.tag, "flush_cnt", 32'(f_cnt), x.f);
      chk(x.tag, "err", 32'(err), 32'(x.err));
      $display("txn %-8s en=%b fl=%b sel=%0d st=%0d s=%0d b=%0d f=%0d err=%b %s",
               x.tag, {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, {ifid_fl, idex_fl},
               sel, dut.state_q, s_cnt, b_cnt, f_cnt, err, (errors == e0) ? "ok" : "bad");
    end
  end

  // Bound the whole run.
  initial begin
    #20000;
    $display("FAIL timeout: stimulus did not complete, done=%0d expected 1", stim_done);
    $fatal(1, "simulation time limit");
  end

  initial begin
    //   tag       r  hd br ir is dq ds  en  fl     sel   state      s   b  f  err
    // 1: reset with all inputs high, then release idle
    vec("rst0",    0, 1, 1, 1, 1, 1, 1, Z,  2'b00, zero, RUN,       0,  0, 0, 0);
    vec("rst1",    0, 1, 1, 1, 1, 1, 1, Z,  2'b00, zero, RUN,       0,  0, 0, 0);
    vec("rst2",    0, 1, 1, 1, 1, 1, 1, Z,  2'b00, zero, RUN,       0,  0, 0, 0);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       0,  0, 0, 0);
    // 2: single load-use bubble
    vec("lu",      1, 1, 0, 0, 0, 0, 0, BU, 2'b00, zero, RUN,       0,  0, 0, 0);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       0,  1, 0, 0);
    vec("isame",   1, 0, 0, 1, 1, 0, 0, A,  2'b00, ctrl, RUN,       0,  1, 0, 0);
    // 3: dmem wait 5 cycles; watchdog (TIMEOUT=4) trips after the 4th wait edge
    vec("dw1",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, RUN,       0,  1, 0, 0);
    vec("dw2",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 1,  1, 0, 0);
    vec("dw3",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 2,  1, 0, 0);
    vec("dw4",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 3,  1, 0, 0);
    vec("dw5",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 4,  1, 0, 1);
    vec("dresp",   1, 0, 0, 0, 0, 1, 1, A,  2'b00, ctrl, DMEM_WAIT, 5,  1, 0, 1);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       5,  1, 0, 1);
    // 4: redirect overrides load-use
    vec("br_hd",   1, 1, 1, 0, 0, 0, 0, A,  2'b11, zero, RUN,       5,  1, 0, 1);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       5,  1, 1, 1);
    // 5: imem wait cycles 1..3, dmem wait cycles 2..6
    vec("iw1",     1, 0, 0, 1, 0, 0, 0, Z,  2'b00, ctrl, RUN,       5,  1, 1, 1);
    vec("iw2",     1, 0, 0, 1, 0, 1, 0, Z,  2'b00, ctrl, IMEM_WAIT, 6,  1, 1, 1);
    vec("iw3",     1, 0, 0, 1, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 7,  1, 1, 1);
    vec("dw4b",    1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 8,  1, 1, 1);
    vec("dw5b",    1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 9,  1, 1, 1);
    vec("dw6b",    1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 10, 1, 1, 1);
    vec("dresp",   1, 0, 0, 0, 0, 1, 1, A,  2'b00, ctrl, DMEM_WAIT, 11, 1, 1, 1);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       11, 1, 1, 1);
    // DMEM -> IMEM move
    vec("d2i_1",   1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, RUN,       11, 1, 1, 1);
    vec("d2i_2",   1, 0, 0, 1, 0, 0, 0, Z,  2'b00, ctrl, DMEM_WAIT, 12, 1, 1, 1);
    vec("d2i_3",   1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, IMEM_WAIT, 13, 1, 1, 1);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       13, 1, 1, 1);
    // redirect held across a freeze is honoured on the unfreeze cycle
    vec("brfz",    1, 0, 1, 0, 0, 1, 0, Z,  2'b00, ctrl, RUN,       13, 1, 1, 1);
    vec("brgo",    1, 0, 1, 0, 0, 1, 1, A,  2'b11, zero, DMEM_WAIT, 14, 1, 1, 1);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       14, 1, 2, 1);
    // stall counter saturates at 15
    vec("sat1",    1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, RUN,       14, 1, 2, 1);
    vec("sat2",    1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 15, 1, 2, 1);
    vec("sat3",    1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 15, 1, 2, 1);
    vec("sat4",    1, 0, 0, 0, 0, 1, 1, A,  2'b00, ctrl, DMEM_WAIT, 15, 1, 2, 1);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       15, 1, 2, 1);
    // load-use held across a freeze
    vec("hdfz",    1, 1, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, RUN,       15, 1, 2, 1);
    vec("hdgo",    1, 1, 0, 0, 0, 1, 1, BU, 2'b00, zero, DMEM_WAIT, 15, 1, 2, 1);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       15, 2, 2, 1);
    // 6: reset clears, watchdog trips on a never-answered dmem request, sticks until reset
    vec("rst",     0, 0, 0, 0, 0, 0, 0, Z,  2'b00, zero, RUN,       0,  0, 0, 0);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       0,  0, 0, 0);
    vec("to1",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, RUN,       0,  0, 0, 0);
    vec("to2",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 1,  0, 0, 0);
    vec("to3",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 2,  0, 0, 0);
    vec("to4",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 3,  0, 0, 0);
    vec("to5",     1, 0, 0, 0, 0, 1, 0, Z,  2'b00, ctrl, DMEM_WAIT, 4,  0, 0, 1);
    vec("toresp",  1, 0, 0, 0, 0, 1, 1, A,  2'b00, ctrl, DMEM_WAIT, 5,  0, 0, 1);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       5,  0, 0, 1);
    vec("rst",     0, 0, 0, 0, 0, 0, 0, Z,  2'b00, zero, RUN,       0,  0, 0, 0);
    vec("run",     1, 0, 0, 0, 0, 0, 0, A,  2'b00, ctrl, RUN,       0,  0, 0, 0);
    stim_done = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_stall_ctrl
